// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg
//   Shared types and geometry for the 2-way, 8-set, 256-bit-line L2 cache.
//   state_t   : controller sequencing states
//   line_addr : builds a line-aligned memory address from tag and set index
package l2_cache_pkg;
  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 24;
  localparam int LINE_W   = 256;

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;

  function automatic logic [31:0] line_addr(input logic [S_TAG-1:0] tag,
                                            input logic [S_INDEX-1:0] idx);
    return {tag, idx, {S_OFFSET{1'b0}}};
  endfunction
endpackage

// File: rtl/l2_cache_control_if.sv
// l2_cache_control_if
//   Upstream (L1 arbiter) request/response bus plus the physical memory port.
//   slave  : the cache controller's view (takes requests, drives pmem)
//   master : the requester / memory side's view
interface l2_cache_control_if;
  import l2_cache_pkg::*;

  logic [31:0]       addr_i;
  logic              read_i;
  logic              write_i;
  logic [LINE_W-1:0] wdata_i;
  logic [LINE_W-1:0] rdata_o;
  logic              resp_o;
  logic [31:0]       pmem_addr_o;
  logic              pmem_read_o;
  logic              pmem_write_o;
  logic [LINE_W-1:0] pmem_wdata_o;
  logic [LINE_W-1:0] pmem_rdata_i;
  logic              pmem_resp_i;

  modport slave (
    input  addr_i, read_i, write_i, wdata_i, pmem_rdata_i, pmem_resp_i,
    output rdata_o, resp_o, pmem_addr_o, pmem_read_o, pmem_write_o, pmem_wdata_o
  );

  modport master (
    output addr_i, read_i, write_i, wdata_i, pmem_rdata_i, pmem_resp_i,
    input  rdata_o, resp_o, pmem_addr_o, pmem_read_o, pmem_write_o, pmem_wdata_o
  );
endinterface

// File: rtl/l2_hit_detect.sv
// l2_hit_detect
//   Combinational tag/valid compare across all ways.
//   i_tag       : request tag
//   i_way_tag   : per-way stored tag
//   i_way_valid : per-way valid
//   o_hit       : any way matches; o_hit_way : lowest matching way
module l2_hit_detect #(
  parameter int NUM_WAYS = 2,
  parameter int S_TAG    = 24
) (
  input  logic [S_TAG-1:0]                   i_tag,
  input  logic [NUM_WAYS-1:0][S_TAG-1:0]     i_way_tag,
  input  logic [NUM_WAYS-1:0]                i_way_valid,
  output logic                               o_hit,
  output logic [$clog2(NUM_WAYS)-1:0]        o_hit_way
);
  logic [NUM_WAYS-1:0] w_match;

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_cmp
    assign w_match[gi] = i_way_valid[gi] && (i_way_tag[gi] == i_tag);
  end

  always_comb begin
    o_hit     = |w_match;
    o_hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) o_hit_way = i[$clog2(NUM_WAYS)-1:0];
    end
  end
endmodule

// File: rtl/l2_way.sv
// l2_way
//   One cache way: data line, tag, valid and dirty per set, all with a
//   registered read at i_index and write-to-read forwarding.
//   i_load_data/i_byte_enable/i_data : byte-masked line write
//   i_load_tag/valid/dirty           : metadata writes
//   o_data/o_tag/o_valid/o_dirty     : contents of i_index from the previous cycle
module l2_way
  import l2_cache_pkg::*;
#(
  parameter int s_index = 3,
  parameter int s_tag   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_index-1:0]  i_index,
  input  logic                i_load_data,
  input  logic [LINE_W/8-1:0] i_byte_enable,
  input  logic [LINE_W-1:0]   i_data,
  input  logic                i_load_tag,
  input  logic [s_tag-1:0]    i_tag,
  input  logic                i_load_valid,
  input  logic                i_valid,
  input  logic                i_load_dirty,
  input  logic                i_dirty,
  output logic [LINE_W-1:0]   o_data,
  output logic [s_tag-1:0]    o_tag,
  output logic                o_valid,
  output logic                o_dirty
);
  reg_array #(.s_index(s_index), .width(s_tag)) u_tag (
    .clk, .rst, .i_load(i_load_tag), .i_rindex(i_index), .i_windex(i_index),
    .i_datain(i_tag), .o_dataout(o_tag));
  reg_array #(.s_index(s_index), .width(1)) u_valid (
    .clk, .rst, .i_load(i_load_valid), .i_rindex(i_index), .i_windex(i_index),
    .i_datain(i_valid), .o_dataout(o_valid));
  reg_array #(.s_index(s_index), .width(1)) u_dirty (
    .clk, .rst, .i_load(i_load_dirty), .i_rindex(i_index), .i_windex(i_index),
    .i_datain(i_dirty), .o_dataout(o_dirty));

  // Data is split into byte lanes so each lane maps onto a plain RAM with
  // its own write enable; no reset so it can live in block RAM.
  for (genvar gi = 0; gi < LINE_W / 8; gi++) begin : g_byte
    logic [7:0] r_mem [1 << s_index];
    logic [7:0] r_q;
    always_ff @(posedge clk) begin
      if (i_load_data && i_byte_enable[gi]) begin
        r_mem[i_index] <= i_data[gi*8 +: 8];
        r_q            <= i_data[gi*8 +: 8];
      end else begin
        r_q <= r_mem[i_index];
      end
    end
    assign o_data[gi*8 +: 8] = r_q;
  end
endmodule

// File: rtl/reg_array.sv
// reg_array
//   Small resettable array with a registered read port.
//   i_load/i_windex/i_datain : write port
//   i_rindex                 : read index, data appears on o_dataout next cycle
//   A write to the index being read is forwarded so the next cycle sees new data.
module reg_array #(
  parameter int s_index = 3,
  parameter int width   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [s_index-1:0] i_rindex,
  input  logic [s_index-1:0] i_windex,
  input  logic [width-1:0]   i_datain,
  output logic [width-1:0]   o_dataout
);
  localparam int NUM_SETS = 1 << s_index;

  logic [width-1:0] r_data [NUM_SETS];
  logic [width-1:0] r_dataout;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) r_data[i] <= '0;
      r_dataout <= '0;
    end else begin
      if (i_load) r_data[i_windex] <= i_datain;
      r_dataout <= (i_load && (i_windex == i_rindex)) ? i_datain : r_data[i_rindex];
    end
  end

  assign o_dataout = r_dataout;
endmodule

// File: rtl/l2_cache_control.sv
// l2_cache_control
//   Sequencer for the 2-way, 8-set, 256-bit-line L2 cache: resolves hit/miss,
//   evicts the per-set LRU way (writing it back when dirty), fills from memory
//   and re-checks so every request completes through the hit path.
//   clk, rst : clock and synchronous active-high reset
//   bus      : upstream request/response and physical memory port (slave view)
module l2_cache_control #(
  parameter int NUM_WAYS = 2,
  parameter int S_INDEX  = 3,
  parameter int S_TAG    = 24
) (
  input  logic               clk,
  input  logic               rst,
  l2_cache_control_if.slave  bus
);
  import l2_cache_pkg::*;

  if (NUM_WAYS != 2) begin : g_bad_ways
    $error("l2_cache_control: only NUM_WAYS=2 is supported");
  end
  if (S_INDEX != l2_cache_pkg::S_INDEX || S_TAG != l2_cache_pkg::S_TAG ||
      S_TAG + S_INDEX + S_OFFSET != 32) begin : g_bad_split
    $error("l2_cache_control: address split does not match the cache geometry");
  end

  state_t                          r_state, w_state_next;
  logic [S_TAG-1:0]                r_tag;
  logic [S_INDEX-1:0]              r_idx;
  logic                            r_write;
  logic [LINE_W-1:0]               r_wdata;
  logic                            r_victim;

  logic [S_INDEX-1:0]              w_index;
  logic [NUM_WAYS-1:0][S_TAG-1:0]  w_way_tag;
  logic [NUM_WAYS-1:0][LINE_W-1:0] w_way_data;
  logic [NUM_WAYS-1:0]             w_way_valid, w_way_dirty;
  logic [NUM_WAYS-1:0]             w_wr_hit, w_fill;
  logic                            w_hit, w_hit_way, w_lru;
  logic                            w_lru_load, w_lru_in, w_accept, w_miss;
  logic                            w_unused_offset;

  assign w_unused_offset = ^bus.addr_i[S_OFFSET-1:0];

  // Arrays read one cycle ahead: in IDLE present the incoming index so CHECK
  // sees the set on the very next cycle; afterwards hold the latched index.
  assign w_index = (r_state == IDLE) ? bus.addr_i[S_OFFSET +: S_INDEX] : r_idx;

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    l2_way #(.s_index(S_INDEX), .s_tag(S_TAG)) u_way (
      .clk, .rst,
      .i_index       (w_index),
      .i_load_data   (w_wr_hit[gi] | w_fill[gi]),
      .i_byte_enable ({(LINE_W/8){1'b1}}),
      .i_data        (w_fill[gi] ? bus.pmem_rdata_i : r_wdata),
      .i_load_tag    (w_fill[gi]),
      .i_tag         (r_tag),
      .i_load_valid  (w_fill[gi]),
      .i_valid       (1'b1),
      .i_load_dirty  (w_wr_hit[gi] | w_fill[gi]),
      .i_dirty       (w_wr_hit[gi]),
      .o_data        (w_way_data[gi]),
      .o_tag         (w_way_tag[gi]),
      .o_valid       (w_way_valid[gi]),
      .o_dirty       (w_way_dirty[gi]));
  end

  // One bit per set naming the least recently used way.
  reg_array #(.s_index(S_INDEX), .width(1)) u_lru (
    .clk, .rst, .i_load(w_lru_load), .i_rindex(w_index), .i_windex(r_idx),
    .i_datain(w_lru_in), .o_dataout(w_lru));

  l2_hit_detect #(.NUM_WAYS(NUM_WAYS), .S_TAG(S_TAG)) u_hit (
    .i_tag(r_tag), .i_way_tag(w_way_tag), .i_way_valid(w_way_valid),
    .o_hit(w_hit), .o_hit_way(w_hit_way));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tag    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_victim <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_tag   <= bus.addr_i[31 -: S_TAG];
        r_idx   <= bus.addr_i[S_OFFSET +: S_INDEX];
        r_write <= bus.write_i;   // read+write together counts as a write
      end
      if (w_miss) r_victim <= w_lru;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_wdata <= bus.wdata_i;
  end

  always_comb begin
    w_state_next     = r_state;
    w_accept         = 1'b0;
    w_miss           = 1'b0;
    w_wr_hit         = '0;
    w_fill           = '0;
    w_lru_load       = 1'b0;
    w_lru_in         = 1'b0;
    bus.resp_o       = 1'b0;
    bus.rdata_o      = '0;
    bus.pmem_read_o  = 1'b0;
    bus.pmem_write_o = 1'b0;
    bus.pmem_addr_o  = '0;
    bus.pmem_wdata_o = '0;
    case (r_state)
      IDLE: begin
        if (bus.read_i || bus.write_i) begin
          w_accept     = 1'b1;
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        if (w_hit) begin
          bus.resp_o = 1'b1;
          w_lru_load = 1'b1;
          w_lru_in   = ~w_hit_way;
          if (r_write) w_wr_hit[w_hit_way] = 1'b1;
          else         bus.rdata_o = w_way_data[w_hit_way];
          w_state_next = IDLE;
        end else begin
          w_miss       = 1'b1;
          w_state_next = (w_way_valid[w_lru] && w_way_dirty[w_lru]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        // Set index is held, so victim tag/data stay stable on the array outputs.
        bus.pmem_write_o = 1'b1;
        bus.pmem_addr_o  = line_addr(w_way_tag[r_victim], r_idx);
        bus.pmem_wdata_o = w_way_data[r_victim];
        if (bus.pmem_resp_i) w_state_next = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read_o = 1'b1;
        bus.pmem_addr_o = line_addr(r_tag, r_idx);
        if (bus.pmem_resp_i) begin
          w_fill[r_victim] = 1'b1;
          w_state_next     = CHECK;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control
//   Directed and randomized bench for l2_cache_control. A recency-ordered set
//   model and a reference memory predict response data, memory traffic and latency.
module tb_l2_cache_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_cache_control_if bus ();
  l2_cache_control dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [23:0] tag; logic [255:0] data; bit dirty; } ent_t;
  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } ev_t;

  ent_t          sets [8][$];          // per set, index 0 = least recently used
  logic [255:0]  ref_mem  [logic [31:0]];
  logic [255:0]  phys_mem [logic [31:0]];
  ev_t           exp_q [$];
  logic [255:0]  exp_rdata;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h9E37_79B9 * (i + 1));
    return l;
  endfunction

  function automatic logic [255:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_line(a);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) sets[s].delete();
  endtask

  // Fills exp_q with the expected memory traffic and exp_rdata with the line.
  task automatic model_access(input logic [31:0] a, input bit wr, input logic [255:0] wd);
    logic [2:0]  idx;
    logic [23:0] tag;
    logic [31:0] la;
    int          pos;
    ent_t        e, v;
    idx = a[7:5];
    tag = a[31:8];
    pos = -1;
    exp_q.delete();
    for (int i = 0; i < sets[idx].size(); i++) if (sets[idx][i].tag == tag) pos = i;
    if (pos >= 0) begin
      e = sets[idx][pos];
      sets[idx].delete(pos);
    end else begin
      if (sets[idx].size() == 2) begin
        v = sets[idx].pop_front();
        if (v.dirty) begin
          la = {v.tag, idx, 5'b0};
          exp_q.push_back('{1'b1, la, v.data});
          ref_mem[la] = v.data;
        end
      end
      la = {tag, idx, 5'b0};
      exp_q.push_back('{1'b0, la, '0});
      e.tag   = tag;
      e.data  = ref_rd(la);
      e.dirty = 1'b0;
    end
    if (wr) begin
      e.data  = wd;
      e.dirty = 1'b1;
    end
    exp_rdata = e.data;
    sets[idx].push_back(e);
  endtask

  task automatic access(input string name, input logic [31:0] a, input bit rd, input bit wr,
                        input logic [255:0] wd, input int lat);
    ev_t          obs_q [$];
    int           cycles, wait_cnt, both, exp_cycles;
    bit           got, stable, active;
    logic [31:0]  t_addr;
    logic [255:0] t_wdata, got_rdata;
    model_access(a, wr, wd);
    exp_cycles = 1 + ((exp_q.size() != 0) ? 1 : 0) + lat * exp_q.size();
    @(negedge clk);
    bus.addr_i = a; bus.read_i = rd; bus.write_i = wr; bus.wdata_i = wd;
    cycles = 0; wait_cnt = 0; both = 0; got = 0; stable = 1; active = 0;
    t_addr = '0; t_wdata = '0; got_rdata = '0;
    while (!got && cycles < 400) begin
      @(negedge clk);
      cycles++;
      bus.pmem_resp_i  = 1'b0;
      bus.pmem_rdata_i = '0;
      if (bus.pmem_read_o && bus.pmem_write_o) both++;
      if (bus.resp_o) begin
        got = 1; got_rdata = bus.rdata_o;
        bus.read_i = 1'b0; bus.write_i = 1'b0;
      end else if (bus.pmem_read_o || bus.pmem_write_o) begin
        if (!active) begin
          active = 1; wait_cnt = 0;
          t_addr = bus.pmem_addr_o; t_wdata = bus.pmem_wdata_o;
        end else if (bus.pmem_addr_o !== t_addr ||
                     (bus.pmem_write_o && bus.pmem_wdata_o !== t_wdata)) begin
          stable = 0;
        end
        wait_cnt++;
        if (wait_cnt >= lat) begin
          obs_q.push_back('{bus.pmem_write_o, t_addr, t_wdata});
          if (bus.pmem_write_o) phys_mem[t_addr] = t_wdata;
          else                  bus.pmem_rdata_i = phys_rd(t_addr);
          bus.pmem_resp_i = 1'b1;
          active = 0;
        end
      end
    end
    chk({name, "_resp"}, got, 1);
    chk({name, "_latency"}, cycles, exp_cycles);
    chk({name, "_pmem_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_ev%0d_kind", name, i), obs_q[i].wr, exp_q[i].wr);
      chk($sformatf("%s_ev%0d_addr", name, i), obs_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk($sformatf("%s_ev%0d_wdata", name, i), obs_q[i].data, exp_q[i].data);
    end
    if (!wr) chk({name, "_rdata"}, got_rdata, exp_rdata);
    chk({name, "_pmem_stable"}, stable, 1);
    chk({name, "_rw_exclusive"}, both, 0);
    @(negedge clk);
    chk({name, "_single_pulse"}, bus.resp_o, 0);
    $display("txn %s addr=%08h rd=%0d wr=%0d lat=%0d cycles=%0d pmem_ops=%0d",
             name, a, rd, wr, lat, cycles, obs_q.size());
  endtask

  initial begin
    logic [255:0] line_b;
    logic [31:0]  a;
    logic [23:0]  t;
    int           n, op;

    bus.addr_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0; bus.wdata_i = '0;
    bus.pmem_rdata_i = '0; bus.pmem_resp_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_resp", bus.resp_o, 0);
    chk("reset_pmem_read", bus.pmem_read_o, 0);
    chk("reset_pmem_write", bus.pmem_write_o, 0);
    chk("reset_pmem_addr", bus.pmem_addr_o, 0);
    rst = 1'b0;

    // Clean miss, then the same line hits with no memory traffic.
    access("t1_miss", 32'h0000_1000, 1, 0, '0, 3);
    access("t2_hit", 32'h0000_1000, 1, 0, '0, 3);

    // Dirty line in set 0 is written back before the third tag is filled.
    line_b = rand_line();
    access("t3_wr_hit", 32'h0000_1000, 0, 1, line_b, 2);
    access("t3_rd_2000", 32'h0000_2000, 1, 0, '0, 2);
    access("t3_rd_3000", 32'h0000_3000, 1, 0, '0, 2);

    // LRU ordering.
    access("t4_a", 32'h0000_1000, 1, 0, '0, 1);
    access("t4_b", 32'h0000_2000, 1, 0, '0, 1);
    access("t4_c", 32'h0000_1000, 1, 0, '0, 1);
    access("t4_d", 32'h0000_3000, 1, 0, '0, 1);
    access("t4_e", 32'h0000_1000, 1, 0, '0, 1);

    // Reset while waiting in the fill state.
    @(negedge clk);
    bus.addr_i = 32'h0000_50A0; bus.read_i = 1'b1;
    n = 0;
    while (!bus.pmem_read_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_fill_reached", bus.pmem_read_o, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1; bus.read_i = 1'b0;
    @(negedge clk);
    chk("t5_rst_resp", bus.resp_o, 0);
    chk("t5_rst_rdata", bus.rdata_o, 0);
    chk("t5_rst_pmem_read", bus.pmem_read_o, 0);
    chk("t5_rst_pmem_write", bus.pmem_write_o, 0);
    chk("t5_rst_pmem_addr", bus.pmem_addr_o, 0);
    chk("t5_rst_pmem_wdata", bus.pmem_wdata_o, 0);
    rst = 1'b0;
    model_reset();
    $display("txn t5_reset addr=000050a0 abandoned in fill");
    access("t5_miss", 32'h0000_1000, 1, 0, '0, 2);

    // Slow memory.
    access("t6_slow", 32'h0000_6000, 1, 0, '0, 10);

    // A memory response while idle must not disturb anything.
    @(negedge clk);
    bus.pmem_resp_i = 1'b1; bus.pmem_rdata_i = rand_line();
    @(negedge clk);
    bus.pmem_resp_i = 1'b0; bus.pmem_rdata_i = '0;
    chk("stray_resp_o", bus.resp_o, 0);
    chk("stray_pmem_read", bus.pmem_read_o, 0);
    access("stray_hit", 32'h0000_1000, 1, 0, '0, 2);

    // Randomized traffic over a small tag pool to force conflicts and writebacks.
    for (int k = 0; k < 80; k++) begin
      t  = ($urandom_range(0, 4) == 4) ? 24'hABCDEF : 24'($urandom_range(0, 3));
      a  = {t, 3'($urandom_range(0, 7)), 5'($urandom)};
      op = $urandom_range(0, 3);
      access($sformatf("r%0d", k), a, (op != 2), (op >= 2), rand_line(),
             $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
